// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Shared types for the pipelined immediate extender.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // Widest supported datapath; narrower instances use the low WIDTH bits.
    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_J   = 3'b011,
        IMM_U   = 3'b100,
        IMM_Z   = 3'b101,
        IMM_SH  = 3'b110,
        IMM_RSV = 3'b111
    } imm_src_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            illegal;
    } imm_result_t;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Combinational RV32I/RV64I immediate extraction and pc + imm.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
    import imm_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [31:0]      instr,
    input  imm_src_t         immsrc,
    input  logic [WIDTH-1:0] pc,
    output imm_result_t      result
);

    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_unused_opcode;

    // The opcode field never contributes to any immediate.
    assign w_unused_opcode = ^instr[6:0];

    always_comb begin
        w_imm     = '0;
        w_illegal = 1'b0;
        case (immsrc)
            IMM_I:   w_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S:   w_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   w_imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            IMM_J:   w_imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
            IMM_U:   w_imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
            IMM_Z:   w_imm = {{(XLEN-5){1'b0}}, instr[19:15]};
            IMM_SH:  w_imm = XLEN'(instr[20 +: SHAMT_W]);
            default: w_illegal = 1'b1;
        endcase

        result.imm     = w_imm;
        result.target  = XLEN'(pc) + w_imm;
        result.illegal = w_illegal;
    end

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Registered immediate extender with a 2-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  imm_src_t         immsrc,
    input  logic [WIDTH-1:0] pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] immop,
    output logic [WIDTH-1:0] pc_target,
    output logic             illegal
);

    typedef struct packed {
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] target;
        logic             illegal;
    } entry_t;

    imm_result_t w_dec;
    entry_t      w_new;
    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    logic        out_valid_q, out_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        w_accept;
    logic        w_drain;
    logic        w_unused_dec;

    imm_decode #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_decode (
        .instr  (instr),
        .immsrc (immsrc),
        .pc     (pc),
        .result (w_dec)
    );

    // Bits above WIDTH are unused when the datapath is narrower than XLEN.
    assign w_unused_dec = ^{w_dec.imm, w_dec.target};

    assign in_ready = !skid_valid_q;
    assign w_accept = in_valid && !skid_valid_q;
    assign w_drain  = out_valid_q && out_ready;

    always_comb begin
        w_new.imm     = w_dec.imm[WIDTH-1:0];
        w_new.target  = w_dec.target[WIDTH-1:0];
        w_new.illegal = w_dec.illegal;

        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (w_drain) begin
                out_d        = skid_q;
                out_valid_d  = skid_valid_q;
                skid_valid_d = 1'b0;
            end
            // An accept is only possible with skid empty, so it never collides
            // with a skid-to-out promotion.
            if (w_accept) begin
                if (!out_valid_q || (w_drain && !skid_valid_q)) begin
                    out_d       = w_new;
                    out_valid_d = 1'b1;
                end else begin
                    skid_d       = w_new;
                    skid_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign immop     = out_q.imm;
    assign pc_target = out_q.target;
    assign illegal   = out_q.illegal;

endmodule
`default_nettype wire
